spinn_link_receiver: RTL and testbench
======================================

Name: spinn_link_receiver

Overview:
- Inbound end of the SpiNNaker 2-of-7 NRZ link, i.e. the receive counterpart of spinn_driver.
- Synchronises the 7 link wires into CLK_IN and decodes transition symbols into nibbles.
- Assembles 40-bit (short) or 72-bit (long) packets, checks odd parity, and presents packets on a valid/ready interface.
- Returns the NRZ acknowledge to the sender, withholding it as backpressure when the output register is occupied.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each SL_DATA_2OF7_IN wire (minimum 2).
- CHECK_PARITY, 1, when 1 drop packets with even parity; when 0 deliver all framed packets.

Ports:
- CLK_IN  in  1  system clock (50 MHz).
- RESET_IN  in  1  reset; synchronous, active-high.
- SL_DATA_2OF7_IN  in  7  asynchronous 2-of-7 NRZ link data.
- SL_ACK_OUT  out  1  NRZ acknowledge; toggles once per consumed symbol.
- PKT_DATA_OUT  out  72  packet; short packets in [39:0] with [71:40]=0; bit 0 is the parity bit.
- PKT_LONG_OUT  out  1  1 = 72-bit packet, 0 = 40-bit packet.
- PKT_VLD_OUT  out  1  output holds a packet.
- PKT_RDY_IN  in  1  consumer accepts the packet.
- ERR_OUT  out  1  one-cycle pulse on a code, framing or parity error.

Behaviour:
- Reset (synchronous, active-high):
  - SL_ACK_OUT=0, PKT_VLD_OUT=0, PKT_DATA_OUT=0, PKT_LONG_OUT=0, ERR_OUT=0.
  - nibble count=0; state=RECV.
  - ref register loaded from the synchronised wires every reset cycle, so no phantom symbol appears on release.
- Detection:
  - chg = sync_data XOR ref.
  - popcount(chg) of 0 or 1: wait; this absorbs wire skew.
  - popcount(chg)==2: decode.
  - popcount(chg)>=3: code error.
- Code table, chg to nibble:
  - 0x11→0, 0x12→1, 0x14→2, 0x18→3
  - 0x21→4, 0x22→5, 0x24→6, 0x28→7
  - 0x41→8, 0x42→9, 0x44→A, 0x48→B
  - 0x03→C, 0x0C→D, 0x05→E, 0x0A→F
  - EOP=0x60
  - 0x09, 0x06, 0x30, 0x50 are code errors.
- Consuming a symbol:
  - ref <= sync_data and SL_ACK_OUT toggles on the clock edge after the decode cycle.
  - Latency from the second wire change to the ack toggle is SYNC_STAGES+1 cycles.
- Nibble placement: nibbles arrive least-significant first; nibble k goes to bits [4k+3:4k].
- RECV state:
  - data nibble with count<18: store it, count++.
  - data nibble with count==18: framing error, go to DISCARD.
  - EOP with count of 10 or 18: evaluate the packet.
  - EOP with any other count: framing error, count=0, stay in RECV; the EOP is acked.
- Evaluating a packet at EOP:
  - With CHECK_PARITY=1, the XOR over bits [39:0] (short) or [71:0] (long) must be 1; otherwise pulse ERR_OUT, ack the EOP, discard, count=0.
  - Good packet with output register empty, or emptying in this same cycle (PKT_VLD_OUT&&PKT_RDY_IN): load output, PKT_VLD_OUT=1, PKT_LONG_OUT=(count==18), ack the EOP, count=0.
  - Good packet with output register full: go to HOLD; the EOP is not acked.
- HOLD: wait for the output register to free, then load the packet and ack the EOP, as above. Wire changes seen in HOLD are ignored; the sender is blocked anyway.
- DISCARD: ack every symbol and ignore data until EOP, then count=0 and go to RECV. A code error in any state pulses ERR_OUT, acks, and enters DISCARD.
- Output handshake:
  - PKT_DATA_OUT and PKT_LONG_OUT stay stable while PKT_VLD_OUT=1 && !PKT_RDY_IN.
  - PKT_VLD_OUT clears on accept unless a new packet loads in the same cycle.
- Reset mid-packet: partial packet lost, ack returns to 0. The sender recovers through its own reset or timeout; no requirement on this block.

Decomposition:
- Package spinn_link_pkg:
  - the 17 symbol code constants;
  - EOP_CODE;
  - SHORT_NIBBLES=10 and LONG_NIBBLES=18;
  - state enum (RECV, HOLD, DISCARD).
- Sub-module spinn_2of7_decode, combinational:
  - input: chg[6:0];
  - outputs: nibble[3:0], is_data, is_eop, is_err, is_pending.
- The synchroniser reuses spio_spinnaker_link_sync with SIZE=7.

Test Plan:
- Short packet 40'h0000000001: nibbles 1,0×9 then EOP, each symbol sent after the previous ack → PKT_VLD_OUT=1, PKT_DATA_OUT=72'h1, PKT_LONG_OUT=0, exactly 11 ack toggles, ERR_OUT never set.
- Long packet 72'h80_0000_0000_0000_0003 (odd parity), PKT_RDY_IN=1 → PKT_LONG_OUT=1, data matches, 19 acks.
- Backpressure: PKT_RDY_IN=0, two short packets sent → second EOP not acked and ack frozen; raising PKT_RDY_IN → first packet accepted, second loads and its EOP is acked within 2 cycles.
- Skew: wires 0 and 4 changed 3 cycles apart → nibble 0 decoded once, one ack toggle, no error.
- Errors:
  - chg=0x30 mid-packet → ERR_OUT pulse, symbols acked until EOP, no packet output.
  - EOP after 5 nibbles → ERR_OUT pulse, no packet output.
  - even-parity packet 40'h3 → ERR_OUT pulse, no packet output.
- Reset asserted after 4 nibbles, wires left toggled → SL_ACK_OUT=0, no phantom symbol after release; next full packet is received correctly.

Source files
------------

// File: rtl/spinn_link_pkg.sv
// spinn_link_pkg
//   Shared definitions for the SpiNNaker 2-of-7 link receiver: the transition
//   codes of the sixteen data symbols and the end-of-packet symbol, the two
//   legal packet lengths in nibbles, the receiver state encoding and a popcount
//   helper used by the symbol decoder.
package spinn_link_pkg;

  // Transition code (XOR of old and new wire state) for each data nibble.
  localparam logic [6:0] SYM_0 = 7'h11;
  localparam logic [6:0] SYM_1 = 7'h12;
  localparam logic [6:0] SYM_2 = 7'h14;
  localparam logic [6:0] SYM_3 = 7'h18;
  localparam logic [6:0] SYM_4 = 7'h21;
  localparam logic [6:0] SYM_5 = 7'h22;
  localparam logic [6:0] SYM_6 = 7'h24;
  localparam logic [6:0] SYM_7 = 7'h28;
  localparam logic [6:0] SYM_8 = 7'h41;
  localparam logic [6:0] SYM_9 = 7'h42;
  localparam logic [6:0] SYM_A = 7'h44;
  localparam logic [6:0] SYM_B = 7'h48;
  localparam logic [6:0] SYM_C = 7'h03;
  localparam logic [6:0] SYM_D = 7'h0C;
  localparam logic [6:0] SYM_E = 7'h05;
  localparam logic [6:0] SYM_F = 7'h0A;
  localparam logic [6:0] EOP_CODE = 7'h60;

  // Element n holds the code of nibble value n.
  localparam logic [15:0][6:0] SYM_TABLE = {
    SYM_F, SYM_E, SYM_D, SYM_C, SYM_B, SYM_A, SYM_9, SYM_8,
    SYM_7, SYM_6, SYM_5, SYM_4, SYM_3, SYM_2, SYM_1, SYM_0
  };

  localparam logic [4:0] SHORT_NIBBLES = 5'd10;
  localparam logic [4:0] LONG_NIBBLES  = 5'd18;

  typedef enum logic [1:0] {
    RECV    = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 7; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/spinn_2of7_decode.sv
// spinn_2of7_decode
//   Purely combinational classifier for a 2-of-7 transition pattern.
//   chg        : wires that differ from the last consumed wire state
//   nibble     : decoded data value (valid when is_data)
//   is_data    : chg is one of the sixteen data codes
//   is_eop     : chg is the end-of-packet code
//   is_err     : three or more wires changed, or a two-wire pattern not in use
//   is_pending : fewer than two wires changed; the symbol is still arriving
module spinn_2of7_decode
  import spinn_link_pkg::*;
(
  input  logic [6:0] chg,
  output logic [3:0] nibble,
  output logic       is_data,
  output logic       is_eop,
  output logic       is_err,
  output logic       is_pending
);

  logic [15:0] hit;
  logic [2:0]  pc;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_match
      assign hit[gi] = (chg == SYM_TABLE[gi]);
    end
  endgenerate

  assign pc = popcount7(chg);

  always_comb begin
    nibble     = 4'd0;
    is_data    = 1'b0;
    is_eop     = 1'b0;
    is_err     = 1'b0;
    is_pending = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (hit[i]) nibble = i[3:0];
    end
    if (pc < 3'd2) begin
      is_pending = 1'b1;
    end else if (pc == 3'd2) begin
      if (chg == EOP_CODE) is_eop = 1'b1;
      else if (|hit)       is_data = 1'b1;
      else                 is_err = 1'b1;
    end else begin
      is_err = 1'b1;
    end
  end

endmodule

// File: rtl/spio_spinnaker_link_sync.sv
// spio_spinnaker_link_sync
//   Multi-flop synchroniser for a bus of independent asynchronous wires.
//   CLK_IN : destination clock
//   IN     : asynchronous inputs
//   OUT    : inputs after STAGES flip-flops (STAGES must be at least 2)
// Each wire is synchronised on its own; the 2-of-7 code tolerates wires of
// one symbol resolving in different cycles.
module spio_spinnaker_link_sync #(
  parameter int SIZE   = 7,
  parameter int STAGES = 2
) (
  input  logic            CLK_IN,
  input  logic [SIZE-1:0] IN,
  output logic [SIZE-1:0] OUT
);

  logic [STAGES-1:0][SIZE-1:0] sync_reg;

  always_ff @(posedge CLK_IN) begin
    sync_reg[0] <= IN;
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge CLK_IN) begin
        sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  assign OUT = sync_reg[STAGES-1];

endmodule

// File: rtl/spinn_link_receiver.sv
// spinn_link_receiver
//   Receive end of a SpiNNaker 2-of-7 NRZ link. Decodes transition symbols
//   into nibbles, frames 40/72-bit packets, checks odd parity and offers the
//   packets on a valid/ready port. The NRZ acknowledge is withheld for an EOP
//   while the output register is still occupied, which stalls the sender.
//   CLK_IN          : system clock
//   RESET_IN        : synchronous active-high reset
//   SL_DATA_2OF7_IN : asynchronous link wires
//   SL_ACK_OUT      : NRZ ack, toggles once per consumed symbol
//   PKT_DATA_OUT    : packet (short packets zero-extended), bit 0 = parity
//   PKT_LONG_OUT    : 1 for a 72-bit packet
//   PKT_VLD_OUT     : output register holds a packet
//   PKT_RDY_IN      : consumer takes the packet this cycle
//   ERR_OUT         : one-cycle pulse on code, framing or parity error
module spinn_link_receiver
  import spinn_link_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  input  logic [6:0]  SL_DATA_2OF7_IN,
  output logic        SL_ACK_OUT,
  output logic [71:0] PKT_DATA_OUT,
  output logic        PKT_LONG_OUT,
  output logic        PKT_VLD_OUT,
  input  logic        PKT_RDY_IN,
  output logic        ERR_OUT
);

  logic [6:0]  sync_data;
  logic [6:0]  ref_reg;
  logic [6:0]  chg;
  logic [3:0]  dec_nibble;
  logic        dec_data, dec_eop, dec_err, dec_pending;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg;
  logic [71:0] asm_reg;
  logic [71:0] pkt_data_reg;
  logic        pkt_long_reg, pkt_vld_reg, ack_reg, err_reg;

  logic        is_long, frame_ok, parity_ok, out_free;
  logic        consume, load_pkt, raise_err, store_nibble, clear_count;

  spio_spinnaker_link_sync #(.SIZE(7), .STAGES(SYNC_STAGES)) u_sync (
    .CLK_IN (CLK_IN),
    .IN     (SL_DATA_2OF7_IN),
    .OUT    (sync_data)
  );

  assign chg = sync_data ^ ref_reg;

  spinn_2of7_decode u_decode (
    .chg        (chg),
    .nibble     (dec_nibble),
    .is_data    (dec_data),
    .is_eop     (dec_eop),
    .is_err     (dec_err),
    .is_pending (dec_pending)
  );

  assign is_long   = (count_reg == LONG_NIBBLES);
  assign frame_ok  = (count_reg == SHORT_NIBBLES) || is_long;
  assign parity_ok = !CHECK_PARITY || (is_long ? ^asm_reg : ^asm_reg[39:0]);
  // The output register may be reloaded in the same cycle it is accepted.
  assign out_free  = !pkt_vld_reg || PKT_RDY_IN;

  always_comb begin
    consume      = 1'b0;
    load_pkt     = 1'b0;
    raise_err    = 1'b0;
    store_nibble = 1'b0;
    clear_count  = 1'b0;
    state_next   = state_reg;
    case (state_reg)
      RECV: begin
        if (!dec_pending) begin
          if (dec_err) begin
            consume = 1'b1; raise_err = 1'b1; clear_count = 1'b1;
            state_next = DISCARD;
          end else if (dec_data) begin
            consume = 1'b1;
            if (count_reg < LONG_NIBBLES) begin
              store_nibble = 1'b1;
            end else begin
              raise_err = 1'b1; clear_count = 1'b1;
              state_next = DISCARD;
            end
          end else if (!frame_ok || !parity_ok) begin
            // Bad EOP: acked so the sender moves on to its next packet.
            consume = 1'b1; raise_err = 1'b1; clear_count = 1'b1;
          end else if (out_free) begin
            consume = 1'b1; load_pkt = 1'b1; clear_count = 1'b1;
          end else begin
            // Good EOP but nowhere to put it: the withheld ack is the backpressure.
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        // Wire activity is ignored here; the sender cannot move without our ack.
        if (out_free) begin
          consume = 1'b1; load_pkt = 1'b1; clear_count = 1'b1;
          state_next = RECV;
        end
      end
      DISCARD: begin
        if (!dec_pending) begin
          consume = 1'b1;
          if (dec_err) begin
            raise_err = 1'b1;
          end else if (dec_eop) begin
            clear_count = 1'b1;
            state_next  = RECV;
          end
        end
      end
      default: state_next = RECV;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_reg    <= RECV;
      count_reg    <= 5'd0;
      asm_reg      <= 72'd0;
      pkt_data_reg <= 72'd0;
      pkt_long_reg <= 1'b0;
      pkt_vld_reg  <= 1'b0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      // Tracking the wires during reset means nothing is seen on release.
      ref_reg      <= sync_data;
    end else begin
      state_reg <= state_next;
      err_reg   <= raise_err;
      if (consume) begin
        ref_reg <= sync_data;
        ack_reg <= ~ack_reg;
      end
      if (clear_count) begin
        count_reg <= 5'd0;
      end else if (store_nibble) begin
        asm_reg[{count_reg, 2'b00} +: 4] <= dec_nibble;
        count_reg <= count_reg + 5'd1;
      end
      if (load_pkt) begin
        pkt_data_reg <= is_long ? asm_reg : {32'd0, asm_reg[39:0]};
        pkt_long_reg <= is_long;
        pkt_vld_reg  <= 1'b1;
      end else if (pkt_vld_reg && PKT_RDY_IN) begin
        pkt_vld_reg <= 1'b0;
      end
    end
  end

  assign SL_ACK_OUT   = ack_reg;
  assign PKT_DATA_OUT = pkt_data_reg;
  assign PKT_LONG_OUT = pkt_long_reg;
  assign PKT_VLD_OUT  = pkt_vld_reg;
  assign ERR_OUT      = err_reg;

endmodule

// File: tb/tb_spinn_link_receiver.sv
// tb_spinn_link_receiver
//   Directed bench for spinn_link_receiver. The main process plays the link
//   sender (one symbol per received ack) and queues each packet it expects to
//   be delivered; a negedge monitor pops and compares every accepted packet,
//   counts ack toggles and error pulses, and checks output stability under
//   backpressure.
module tb_spinn_link_receiver;

  localparam int SYNC_STAGES = 2;
  localparam logic [6:0] EOP = 7'h60;

  logic        CLK_IN = 1'b0;
  logic        RESET_IN = 1'b1;
  logic [6:0]  SL_DATA_2OF7_IN = 7'd0;
  logic        SL_ACK_OUT;
  logic [71:0] PKT_DATA_OUT;
  logic        PKT_LONG_OUT;
  logic        PKT_VLD_OUT;
  logic        PKT_RDY_IN = 1'b1;
  logic        ERR_OUT;

  always #10 CLK_IN = ~CLK_IN;

  spinn_link_receiver #(.SYNC_STAGES(SYNC_STAGES), .CHECK_PARITY(1'b1)) dut (
    .CLK_IN          (CLK_IN),
    .RESET_IN        (RESET_IN),
    .SL_DATA_2OF7_IN (SL_DATA_2OF7_IN),
    .SL_ACK_OUT      (SL_ACK_OUT),
    .PKT_DATA_OUT    (PKT_DATA_OUT),
    .PKT_LONG_OUT    (PKT_LONG_OUT),
    .PKT_VLD_OUT     (PKT_VLD_OUT),
    .PKT_RDY_IN      (PKT_RDY_IN),
    .ERR_OUT         (ERR_OUT)
  );

  typedef struct packed {
    logic        long_pkt;
    logic [71:0] data;
  } pkt_t;

  pkt_t       exp_q[$];
  pkt_t       mon_exp;
  int         checks = 0;
  int         errors = 0;
  int         ack_toggles = 0;
  int         err_pulses = 0;
  int         pkts_seen = 0;
  logic       ack_prev = 1'b0;
  logic       prev_hold = 1'b0;
  logic [71:0] prev_data = 72'd0;
  logic [6:0] sym_tab [16] = '{7'h11, 7'h12, 7'h14, 7'h18, 7'h21, 7'h22, 7'h24, 7'h28,
                               7'h41, 7'h42, 7'h44, 7'h48, 7'h03, 7'h0C, 7'h05, 7'h0A};

  task automatic check_eq(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge CLK_IN) begin
    if (SL_ACK_OUT !== ack_prev) ack_toggles++;
    ack_prev = SL_ACK_OUT;
    if (ERR_OUT) err_pulses++;
    if (prev_hold && PKT_VLD_OUT) check_eq("hold_stable", PKT_DATA_OUT, prev_data);
    if (PKT_VLD_OUT && PKT_RDY_IN) begin
      pkts_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pkt: got %h long %0d expected none", PKT_DATA_OUT, PKT_LONG_OUT);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("pkt_data", PKT_DATA_OUT, mon_exp.data);
        check_eq("pkt_long", {71'd0, PKT_LONG_OUT}, {71'd0, mon_exp.long_pkt});
        $display("pkt accepted data=%h long=%0d", PKT_DATA_OUT, PKT_LONG_OUT);
      end
    end
    prev_hold = PKT_VLD_OUT && !PKT_RDY_IN;
    prev_data = PKT_DATA_OUT;
  end

  // Waits up to 12 cycles for SL_ACK_OUT to leave a0; n = cycles waited.
  task automatic wait_ack(input logic a0, output bit got, output int n);
    got = 1'b0;
    n = 0;
    while (n < 12 && !got) begin
      @(negedge CLK_IN);
      n++;
      if (SL_ACK_OUT !== a0) got = 1'b1;
    end
  endtask

  task automatic send_sym(input logic [6:0] code, input bit expect_ack, input string name,
                          output int lat);
    logic a0;
    bit got;
    a0 = SL_ACK_OUT;
    SL_DATA_2OF7_IN = SL_DATA_2OF7_IN ^ code;
    wait_ack(a0, got, lat);
    if (got != expect_ack) begin
      checks++;
      errors++;
      $display("FAIL %s_ack: got ack=%0d expected ack=%0d (code %h)", name, got, expect_ack, code);
    end
  endtask

  int first_lat;

  task automatic send_nibbles(input logic [71:0] data, input int first, input int last);
    int lat;
    for (int k = first; k < last; k++) begin
      send_sym(sym_tab[data[4*k +: 4]], 1'b1, "nibble", lat);
      if (k == 0) first_lat = lat;
    end
  endtask

  task automatic send_packet(input logic [71:0] data, input int nnib, input bit eop_acked);
    int lat;
    send_nibbles(data, 0, nnib);
    send_sym(EOP, eop_acked, "eop", lat);
    $display("sent packet data=%h nibbles=%0d", data, nnib);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_IN);
    #1;
  endtask

  int a0, e0, p0, lat, nwait;
  logic ackv;
  bit got;

  initial begin
    // Reset state
    repeat (5) @(negedge CLK_IN);
    #1;
    check_eq("rst_ack", {71'd0, SL_ACK_OUT}, 72'd0);
    check_eq("rst_vld", {71'd0, PKT_VLD_OUT}, 72'd0);
    check_eq("rst_data", PKT_DATA_OUT, 72'd0);
    check_eq("rst_long", {71'd0, PKT_LONG_OUT}, 72'd0);
    check_eq("rst_err", {71'd0, ERR_OUT}, 72'd0);
    @(negedge CLK_IN);
    RESET_IN = 1'b0;
    idle(3);
    @(negedge CLK_IN);

    // Short packet 40'h1
    a0 = ack_toggles; e0 = err_pulses; p0 = pkts_seen;
    exp_q.push_back('{1'b0, 72'h1});
    send_packet(72'h1, 10, 1'b1);
    idle(3);
    check_eq("short_latency", 72'(first_lat), 72'(SYNC_STAGES + 1));
    check_eq("short_acks", 72'(ack_toggles - a0), 72'd11);
    check_eq("short_err", 72'(err_pulses - e0), 72'd0);
    check_eq("short_pkts", 72'(pkts_seen - p0), 72'd1);

    // Long packet
    a0 = ack_toggles; e0 = err_pulses;
    exp_q.push_back('{1'b1, 72'h80_0000_0000_0000_0003});
    send_packet(72'h80_0000_0000_0000_0003, 18, 1'b1);
    idle(3);
    check_eq("long_acks", 72'(ack_toggles - a0), 72'd19);
    check_eq("long_err", 72'(err_pulses - e0), 72'd0);
    check_eq("long_q_empty", 72'(exp_q.size()), 72'd0);

    // Backpressure: two short packets with the consumer stalled
    @(posedge CLK_IN); #1;
    PKT_RDY_IN = 1'b0;
    @(negedge CLK_IN);
    e0 = err_pulses; p0 = pkts_seen;
    exp_q.push_back('{1'b0, 72'h1});
    send_packet(72'h1, 10, 1'b1);
    exp_q.push_back('{1'b0, 72'h7});
    send_packet(72'h7, 10, 1'b0);
    a0 = ack_toggles;
    idle(5);
    check_eq("bp_ack_frozen", 72'(ack_toggles - a0), 72'd0);
    check_eq("bp_first_held", PKT_DATA_OUT, 72'h1);
    check_eq("bp_vld_held", {71'd0, PKT_VLD_OUT}, 72'd1);
    @(posedge CLK_IN); #1;
    ackv = SL_ACK_OUT;
    PKT_RDY_IN = 1'b1;
    wait_ack(ackv, got, nwait);
    check_eq("bp_eop_acked", {71'd0, got}, 72'd1);
    checks++;
    if (nwait > 2) begin
      errors++;
      $display("FAIL bp_release_latency: got %0d cycles expected at most 2", nwait);
    end
    idle(3);
    check_eq("bp_pkts", 72'(pkts_seen - p0), 72'd2);
    check_eq("bp_err", 72'(err_pulses - e0), 72'd0);

    // Skew: nibble 0 arrives as wire 0 then wire 4 three cycles later
    a0 = ack_toggles; e0 = err_pulses;
    exp_q.push_back('{1'b0, 72'h10});
    ackv = SL_ACK_OUT;
    SL_DATA_2OF7_IN = SL_DATA_2OF7_IN ^ 7'h01;
    repeat (3) @(negedge CLK_IN);
    check_eq("skew_no_early_ack", {71'd0, SL_ACK_OUT}, {71'd0, ackv});
    SL_DATA_2OF7_IN = SL_DATA_2OF7_IN ^ 7'h10;
    wait_ack(ackv, got, nwait);
    idle(4);
    check_eq("skew_one_ack", 72'(ack_toggles - a0), 72'd1);
    @(negedge CLK_IN);
    send_nibbles(72'h10, 1, 10);
    send_sym(EOP, 1'b1, "skew_eop", lat);
    idle(3);
    check_eq("skew_acks", 72'(ack_toggles - a0), 72'd11);
    check_eq("skew_err", 72'(err_pulses - e0), 72'd0);
    @(negedge CLK_IN);

    // Code error 0x30 mid-packet; remaining symbols discarded
    e0 = err_pulses; p0 = pkts_seen;
    send_nibbles(72'h321, 0, 3);
    send_sym(7'h30, 1'b1, "code_err", lat);
    send_nibbles(72'h54000, 3, 5);
    send_sym(EOP, 1'b1, "discard_eop", lat);
    idle(3);
    check_eq("code_err_pulse", 72'(err_pulses - e0), 72'd1);
    @(negedge CLK_IN);

    // Framing error: EOP after 5 nibbles
    e0 = err_pulses;
    send_packet(72'h12345, 5, 1'b1);
    idle(3);
    check_eq("frame_err_pulse", 72'(err_pulses - e0), 72'd1);
    @(negedge CLK_IN);

    // Parity error: 40'h3 has even parity
    e0 = err_pulses;
    send_packet(72'h3, 10, 1'b1);
    idle(3);
    check_eq("parity_err_pulse", 72'(err_pulses - e0), 72'd1);
    check_eq("err_no_pkts", 72'(pkts_seen - p0), 72'd0);
    @(negedge CLK_IN);

    // Reset mid-packet with the wires left toggled
    send_nibbles(72'h9876, 0, 4);
    SL_DATA_2OF7_IN = SL_DATA_2OF7_IN ^ sym_tab[5];
    RESET_IN = 1'b1;
    idle(4);
    check_eq("midrst_ack", {71'd0, SL_ACK_OUT}, 72'd0);
    check_eq("midrst_vld", {71'd0, PKT_VLD_OUT}, 72'd0);
    @(negedge CLK_IN);
    RESET_IN = 1'b0;
    idle(1);
    a0 = ack_toggles; e0 = err_pulses; p0 = pkts_seen;
    idle(10);
    check_eq("no_phantom_ack", 72'(ack_toggles - a0), 72'd0);
    check_eq("no_phantom_err", 72'(err_pulses - e0), 72'd0);
    @(negedge CLK_IN);
    exp_q.push_back('{1'b0, 72'h1});
    send_packet(72'h1, 10, 1'b1);
    idle(3);
    check_eq("post_rst_pkts", 72'(pkts_seen - p0), 72'd1);
    check_eq("post_rst_acks", 72'(ack_toggles - a0), 72'd11);

    check_eq("final_q_empty", 72'(exp_q.size()), 72'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
